// File: rtl/twf_mul_ctrl.sv
// twf_mul_ctrl
//   Frame sequencer for a twiddle-factor multiply stage. Accepts the beat
//   stream from the preceding butterfly stage, drives the multiplier enable
//   and twiddle ROM address with zero latency, and delays a valid/SOF/EOF
//   sideband by the multiplier latency.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : beat present on the multiplier data inputs
//   in_sof     : qualifies in_valid; beat is beat 0 of a frame
//   mul_en     : multiplier enable (beat accepted this cycle)
//   mul_addr   : twiddle ROM address for the beat accepted this cycle
//   out_valid  : multiplier outputs hold a real beat
//   out_sof    : that beat is beat 0
//   out_eof    : that beat is beat BEATS-1
//   busy       : sequencer not idle
//   frame_cnt  : completed frames, wraps
//   sof_err    : one-cycle pulse after a protocol violation
module twf_mul_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int BEATS      = 32,
  parameter int ADDR_STEP  = 16,
  parameter int ADDR_BASE  = 64,
  parameter int MUL_LAT    = 1,
  parameter int FCNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  mul_en,
  output logic [ADDR_WIDTH-1:0] mul_addr,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  busy,
  output logic [FCNT_W-1:0]     frame_cnt,
  output logic                  sof_err
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FL_W   = $clog2(MUL_LAT + 1);
  localparam int unsigned LAT_U = MUL_LAT;
  localparam logic [BEAT_W-1:0]     L_LAST = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] L_BASE = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH-1:0] L_STEP = ADDR_WIDTH'(ADDR_STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [BEAT_W-1:0]   r_beat, w_beat_nx, w_idx;
  logic [FL_W-1:0]     r_flush, w_flush_nx;
  logic [FCNT_W-1:0]   r_fcnt;
  logic                r_err;
  logic                w_accept, w_sof_acc, w_last, w_err;
  logic [2:0]          r_sb [MUL_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_flush <= '0;
      r_fcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_beat  <= w_beat_nx;
      r_flush <= w_flush_nx;
      r_err   <= w_err;
      if (w_last) r_fcnt <= r_fcnt + FCNT_W'(1);
    end
  end

  // Sideband {valid, sof, eof} delay line, one stage per multiplier cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT_U; i++) r_sb[i] <= '0;
    end else begin
      r_sb[0] <= {w_accept, w_sof_acc, w_last};
      for (int unsigned i = 1; i < LAT_U; i++) r_sb[i] <= r_sb[i-1];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_beat_nx  = r_beat;
    w_flush_nx = r_flush;
    w_idx      = '0;
    w_accept   = 1'b0;
    w_sof_acc  = 1'b0;
    w_last     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && in_sof) begin
          w_accept   = 1'b1;
          w_sof_acc  = 1'b1;
          w_beat_nx  = BEAT_W'(1);
          w_state_nx = ST_RUN;
        end else if (in_valid) begin
          w_err = 1'b1;
        end
      end
      ST_RUN: begin
        if (in_valid && in_sof) begin
          // Restart: partial frame abandoned, this beat becomes beat 0.
          w_accept  = 1'b1;
          w_sof_acc = 1'b1;
          w_err     = 1'b1;
          w_beat_nx = BEAT_W'(1);
        end else begin
          w_idx = r_beat;
          if (in_valid) begin
            w_accept = 1'b1;
            if (r_beat == L_LAST) begin
              w_last     = 1'b1;
              w_beat_nx  = '0;
              w_flush_nx = FL_W'(MUL_LAT);
              w_state_nx = ST_FLUSH;
            end else begin
              w_beat_nx = r_beat + BEAT_W'(1);
            end
          end
        end
      end
      ST_FLUSH: begin
        if (in_valid && in_sof) begin
          w_accept   = 1'b1;
          w_sof_acc  = 1'b1;
          w_beat_nx  = BEAT_W'(1);
          w_state_nx = ST_RUN;
        end else begin
          w_err = in_valid;
          if (r_flush <= FL_W'(1)) w_state_nx = ST_IDLE;
          else                     w_flush_nx = r_flush - FL_W'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign mul_en    = w_accept;
  assign mul_addr  = L_BASE + ADDR_WIDTH'(w_idx) * L_STEP;
  assign out_valid = r_sb[MUL_LAT-1][2];
  assign out_sof   = r_sb[MUL_LAT-1][1];
  assign out_eof   = r_sb[MUL_LAT-1][0];
  assign busy      = (r_state != ST_IDLE);
  assign frame_cnt = r_fcnt;
  assign sof_err   = r_err;

endmodule

// File: tb/tb_twf_mul_ctrl.sv
module tb_twf_mul_ctrl;

  localparam int AW = 9;
  localparam int BEATS = 32;
  localparam int STEP = 16;
  localparam int BASE = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;

  logic          en_w    [2];
  logic [AW-1:0] addr_w  [2];
  logic          ov_w    [2];
  logic          os_w    [2];
  logic          oe_w    [2];
  logic          busy_w  [2];
  logic [7:0]    fcnt_w  [2];
  logic          err_w   [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  twf_mul_ctrl #(.ADDR_WIDTH(AW), .BEATS(BEATS), .ADDR_STEP(STEP),
                 .ADDR_BASE(BASE), .MUL_LAT(1), .FCNT_W(8)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .mul_en(en_w[0]), .mul_addr(addr_w[0]), .out_valid(ov_w[0]),
    .out_sof(os_w[0]), .out_eof(oe_w[0]), .busy(busy_w[0]),
    .frame_cnt(fcnt_w[0]), .sof_err(err_w[0]));

  twf_mul_ctrl #(.ADDR_WIDTH(AW), .BEATS(BEATS), .ADDR_STEP(STEP),
                 .ADDR_BASE(BASE), .MUL_LAT(3), .FCNT_W(8)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .mul_en(en_w[1]), .mul_addr(addr_w[1]), .out_valid(ov_w[1]),
    .out_sof(os_w[1]), .out_eof(oe_w[1]), .busy(busy_w[1]),
    .frame_cnt(fcnt_w[1]), .sof_err(err_w[1]));

  // Reference model: position of the next beat inside the open frame
  // (-1 = no open frame), drain cycles left after a frame end, completed
  // frame count, last cycle's violation, and the delayed sideband history.
  int       lat    [2] = '{1, 3};
  int       pos    [2];
  int       tail   [2];
  int       frames [2];
  bit       err_r  [2];
  bit [2:0] hist   [2][4];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int d);
    pos[d] = -1;
    tail[d] = 0;
    frames[d] = 0;
    err_r[d] = 1'b0;
    for (int i = 0; i < 4; i++) hist[d][i] = 3'b000;
  endtask

  task automatic step(input int d);
    bit acc, err, last;
    int idx, addr;
    bit [2:0] sb;
    if (!rst_n) model_clear(d);
    acc  = in_valid && (in_sof || pos[d] >= 0);
    err  = in_valid && ((pos[d] < 0) ? !in_sof : in_sof);
    last = acc && !in_sof && (pos[d] == BEATS - 1);
    idx  = (pos[d] >= 0 && !(in_valid && in_sof)) ? pos[d] : 0;
    addr = (BASE + idx * STEP) % (1 << AW);
    sb   = hist[d][lat[d]-1];
    check($sformatf("mul_en[L%0d]", lat[d]),    32'(en_w[d]),   32'(acc));
    check($sformatf("mul_addr[L%0d]", lat[d]),  32'(addr_w[d]), 32'(addr));
    check($sformatf("busy[L%0d]", lat[d]),      32'(busy_w[d]), 32'(pos[d] >= 0 || tail[d] > 0));
    check($sformatf("frame_cnt[L%0d]", lat[d]), 32'(fcnt_w[d]), 32'(frames[d] % 256));
    check($sformatf("sof_err[L%0d]", lat[d]),   32'(err_w[d]),  32'(err_r[d]));
    check($sformatf("out_valid[L%0d]", lat[d]), 32'(ov_w[d]),   32'(sb[2]));
    check($sformatf("out_sof[L%0d]", lat[d]),   32'(os_w[d]),   32'(sb[1]));
    check($sformatf("out_eof[L%0d]", lat[d]),   32'(oe_w[d]),   32'(sb[0]));
    if (rst_n) begin
      for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
      hist[d][0] = {acc, acc && in_sof, last};
      err_r[d] = err;
      if (tail[d] > 0) tail[d]--;
      if (acc) begin
        if (in_sof) pos[d] = 1;
        else if (last) begin
          pos[d] = -1;
          frames[d]++;
          tail[d] = lat[d];
        end else pos[d]++;
      end
    end
  endtask

  task automatic cycle(input bit v, input bit s);
    @(negedge clk);
    in_valid = v;
    in_sof = s;
    #1;
    step(0);
    step(1);
  endtask

  task automatic frame(input int n);
    for (int b = 0; b < n; b++) cycle(1'b1, b == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    step(0);
    step(1);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single full-rate frame, address wraps after 496.
    frame(BEATS);
    idle(6);

    // Gapped frame: valid pattern 1,0,0 repeated.
    for (int b = 0; b < BEATS; b++) begin
      cycle(1'b1, b == 0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
    end
    idle(6);

    // Back-to-back frames.
    frame(BEATS);
    frame(BEATS);
    idle(6);

    // Restart at beat 10.
    frame(10);
    frame(BEATS);
    idle(6);

    // Stray beats without SOF in idle.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    idle(4);

    // Reset mid-frame at beat 20, then a clean frame.
    frame(20);
    apply_reset();
    idle(1);
    frame(BEATS);
    idle(6);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      bit v, s;
      v = ($urandom_range(0, 99) < 75);
      if (pos[0] < 0) s = ($urandom_range(0, 3) != 0);
      else            s = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 999) == 0) apply_reset();
      cycle(v, s);
    end
    idle(6);

    // Enough back-to-back frames to wrap the frame counter.
    for (int f = 0; f < 257; f++) frame(BEATS);
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
